// File: rtl/sysreg_arb_pkg.sv
// Shared definitions for the system register bus arbiter: sequencer states,
// access owner IDs and default bus widths.
package sysreg_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_t;

    // Owner of the access currently on the register port
    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    // States in which a new access may be granted
    function automatic logic is_arb_state(input arb_state_t s);
        return (s == ST_IDLE) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/sysreg_host_slot.sv
// Single-entry holding latch for host accesses. The host path cannot be
// stalled, so a request that finds the entry occupied is dropped and flagged
// in a sticky overrun bit.
module sysreg_host_slot
    import sysreg_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              take,
    input  logic              drop,
    input  logic              overrun_clr,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_d,
    output logic              full,
    output logic              held_we,
    output logic [ADDR_W-1:0] held_a,
    output logic [DATA_W-1:0] held_d,
    output logic              overrun
);

    // Occupancy: a load in the same cycle as a take keeps the entry full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

    // Captured access fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_we <= 1'b0;
            held_a  <= '0;
            held_d  <= '0;
        end else if (load) begin
            held_we <= req_we;
            held_a  <= req_a;
            held_d  <= req_d;
        end
    end

    // Sticky overrun; a new drop wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sysreg_bus_arbiter.sv
// Shares the single system register file port between the non-stallable
// host path and a req/ack debug master. Each access runs STROBE then
// CAPTURE; a new grant may be issued in IDLE or CAPTURE so accesses can
// run back to back at one per two cycles.
module sysreg_bus_arbiter
    import sysreg_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_a,
    input  logic [DATA_W-1:0] host_d,
    output logic [DATA_W-1:0] host_q,
    output logic              host_valid,
    output logic              host_overrun,
    input  logic              host_overrun_clr,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_a,
    input  logic [DATA_W-1:0] dbg_d,
    output logic [DATA_W-1:0] dbg_q,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_d,
    input  logic [DATA_W-1:0] reg_q,
    output logic              reg_rd,
    output logic              reg_wr
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              owner;
    logic              acc_we;
    logic [3:0]        starve_cnt;

    logic              slot_full;
    logic              slot_we;
    logic [ADDR_W-1:0] slot_a;
    logic [DATA_W-1:0] slot_d;
    logic              slot_load;
    logic              slot_take;
    logic              slot_drop;

    logic              host_pend;
    logic              dbg_busy;
    logic              dbg_pend;
    logic              arb_en;
    logic              grant_host;
    logic              grant_dbg;
    logic              grant_any;
    logic              win_we;
    logic [ADDR_W-1:0] win_a;
    logic [DATA_W-1:0] win_d;

    sysreg_host_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (slot_load),
        .take        (slot_take),
        .drop        (slot_drop),
        .overrun_clr (host_overrun_clr),
        .req_we      (host_we),
        .req_a       (host_a),
        .req_d       (host_d),
        .full        (slot_full),
        .held_we     (slot_we),
        .held_a      (slot_a),
        .held_d      (slot_d),
        .overrun     (host_overrun)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, host slot control, winner select and next state
    always_comb begin
        host_pend  = slot_full | host_req;
        // The debug master holds dbg_req until it has seen dbg_ack, so its
        // request is ignored while its own access is in flight or completing.
        dbg_busy   = ((owner == OWN_DBG) && (state != ST_IDLE)) | dbg_ack;
        dbg_pend   = dbg_req & ~dbg_busy;
        arb_en     = is_arb_state(state);

        grant_dbg  = arb_en & dbg_pend & (~host_pend | (starve_cnt == LIMIT));
        grant_host = arb_en & host_pend & ~grant_dbg;
        grant_any  = grant_host | grant_dbg;

        // A host request arriving with the slot empty and granted at once
        // bypasses the latch; otherwise it is held or, if no room, dropped.
        slot_take  = grant_host & slot_full;
        slot_load  = host_req & ~(grant_host & ~slot_full) & (~slot_full | slot_take);
        slot_drop  = host_req & slot_full & ~slot_take;

        win_we = host_we;
        win_a  = host_a;
        win_d  = host_d;
        if (grant_dbg) begin
            win_we = dbg_we;
            win_a  = dbg_a;
            win_d  = dbg_d;
        end else if (slot_full) begin
            win_we = slot_we;
            win_a  = slot_a;
            win_d  = slot_d;
        end

        state_next = state;
        case (state)
            ST_IDLE:    state_next = grant_any ? ST_STROBE : ST_IDLE;
            ST_STROBE:  state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = grant_any ? ST_STROBE : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Register port drive: strobes last exactly one cycle after each grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_a  <= '0;
            reg_d  <= '0;
            reg_rd <= 1'b0;
            reg_wr <= 1'b0;
            acc_we <= 1'b0;
            owner  <= OWN_HOST;
        end else begin
            reg_rd <= 1'b0;
            reg_wr <= 1'b0;
            if (grant_any) begin
                reg_a  <= win_a;
                reg_d  <= win_d;
                reg_rd <= ~win_we;
                reg_wr <= win_we;
                acc_we <= win_we;
                owner  <= grant_dbg ? OWN_DBG : OWN_HOST;
            end
        end
    end

    // Completion: read data capture and one-cycle done pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_q     <= '0;
            dbg_q      <= '0;
            host_valid <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            host_valid <= 1'b0;
            dbg_ack    <= 1'b0;
            if (state == ST_CAPTURE) begin
                if (owner == OWN_HOST) begin
                    host_valid <= 1'b1;
                    if (!acc_we) begin
                        host_q <= reg_q;
                    end
                end else begin
                    dbg_ack <= 1'b1;
                    if (!acc_we) begin
                        dbg_q <= reg_q;
                    end
                end
            end
        end
    end

    // Debug starvation counter, saturating at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_dbg || !dbg_pend) begin
            starve_cnt <= '0;
        end else if (grant_host && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_sysreg_bus_arbiter.sv
// Bench for sysreg_bus_arbiter: a behavioural register file answers the
// register port, and a transaction-level model predicts every output on
// every cycle from a host request queue, a debug request flag and a
// "next grant possible at cycle N" counter.
module tb_sysreg_bus_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int          NCYC  = 4096;

    localparam logic [7:0] RF_INIT [16] = '{
        8'h42, 8'h73, 8'h5c, 8'h19, 8'h80, 8'h3e, 8'hd1, 8'h07,
        8'hb4, 8'h2a, 8'hf0, 8'h66, 8'h91, 8'h0d, 8'hc8, 8'h55
    };

    typedef struct packed {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
    } acc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_req, host_we, host_overrun_clr;
    logic [3:0] host_a;
    logic [7:0] host_d;
    logic [7:0] host_q;
    logic       host_valid, host_overrun;
    logic       dbg_req, dbg_we, dbg_ack;
    logic [3:0] dbg_a;
    logic [7:0] dbg_d, dbg_q;
    logic [3:0] reg_a;
    logic [7:0] reg_d, reg_q;
    logic       reg_rd, reg_wr;

    logic [7:0] rf [16] = RF_INIT;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          cyc = 0;
    bit          in_rst;
    int          free_at;
    int          dbg_busy_to;
    int unsigned starve;
    bit          m_ovr;
    logic [3:0]  m_reg_a;
    logic [7:0]  m_reg_d, m_host_q, m_dbg_q;
    logic [7:0]  mmem [16];
    acc_t        hq[$];
    bit          ev_v [NCYC];
    bit          ev_we [NCYC];
    bit          ev_own [NCYC];
    logic [3:0]  ev_a [NCYC];
    logic [7:0]  ev_d [NCYC];
    bit          cmp_v [NCYC];
    bit          cmp_own [NCYC];
    bit          cmp_rd [NCYC];
    logic [7:0]  cmp_q [NCYC];
    logic [3:0]  strobes[$];
    int          dbg_wait;

    sysreg_bus_arbiter #(
        .ADDR_W       (4),
        .DATA_W       (8),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_a           (host_a),
        .host_d           (host_d),
        .host_q           (host_q),
        .host_valid       (host_valid),
        .host_overrun     (host_overrun),
        .host_overrun_clr (host_overrun_clr),
        .dbg_req          (dbg_req),
        .dbg_we           (dbg_we),
        .dbg_a            (dbg_a),
        .dbg_d            (dbg_d),
        .dbg_q            (dbg_q),
        .dbg_ack          (dbg_ack),
        .reg_a            (reg_a),
        .reg_d            (reg_d),
        .reg_q            (reg_q),
        .reg_rd           (reg_rd),
        .reg_wr           (reg_wr)
    );

    always #5 clk = ~clk;

    // behavioural register file: registered read data
    always @(posedge clk) begin
        if (reg_wr) rf[reg_a] <= reg_d;
        if (reg_rd) reg_q <= rf[reg_a];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, want %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] obs_vec();
        return {31'b0, reg_rd, reg_wr, reg_a, reg_d, host_valid, host_q,
                dbg_ack, dbg_q, host_overrun};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCYC; i++) begin
            ev_v[i]  = 1'b0;
            cmp_v[i] = 1'b0;
        end
        hq.delete();
        free_at = 0; dbg_busy_to = -1; starve = 0; m_ovr = 1'b0;
        m_reg_a = '0; m_reg_d = '0; m_host_q = '0; m_dbg_q = '0;
    endtask

    task automatic sched(input bit own, input acc_t acc);
        ev_v[cyc+1]   = 1'b1;
        ev_own[cyc+1] = own;
        ev_we[cyc+1]  = acc.we;
        ev_a[cyc+1]   = acc.a;
        ev_d[cyc+1]   = acc.d;
        free_at       = cyc + 2;
    endtask

    // decide what the arbiter does with this cycle's inputs
    task automatic model_step();
        bit   dp, hp, drop;
        acc_t inc, acc;
        if (in_rst) return;
        inc  = '{we: host_we, a: host_a, d: host_d};
        dp   = dbg_req && (cyc > dbg_busy_to);
        hp   = (hq.size() > 0) || host_req;
        drop = 1'b0;
        if (cyc >= free_at && dp && (!hp || starve == LIMIT)) begin
            sched(1'b1, '{we: dbg_we, a: dbg_a, d: dbg_d});
            dbg_busy_to = cyc + 3;
            starve = 0;
            if (host_req) begin
                if (hq.size() == 0) hq.push_back(inc); else drop = 1'b1;
            end
        end else if (cyc >= free_at && hp) begin
            if (hq.size() > 0) begin
                acc = hq.pop_front();
                if (host_req) hq.push_back(inc);
            end else begin
                acc = inc;
            end
            sched(1'b0, acc);
            if (!dp) starve = 0;
            else if (starve < LIMIT) starve++;
        end else begin
            if (!dp) starve = 0;
            if (host_req) begin
                if (hq.size() == 0) hq.push_back(inc); else drop = 1'b1;
            end
        end
        if (drop) m_ovr = 1'b1;
        else if (host_overrun_clr) m_ovr = 1'b0;
    endtask

    task automatic tick(input bit hreq, input bit hwe, input bit [3:0] ha, input bit [7:0] hd,
                        input bit clr, input bit dst, input bit dwe, input bit [3:0] da,
                        input bit [7:0] dd);
        bit e_rd, e_wr, e_hv, e_ack;
        @(negedge clk);
        cyc++;
        e_rd = 1'b0; e_wr = 1'b0; e_hv = 1'b0; e_ack = 1'b0;
        if (ev_v[cyc]) begin
            e_rd = !ev_we[cyc];
            e_wr = ev_we[cyc];
            m_reg_a = ev_a[cyc];
            m_reg_d = ev_d[cyc];
            cmp_v[cyc+2]   = 1'b1;
            cmp_own[cyc+2] = ev_own[cyc];
            cmp_rd[cyc+2]  = !ev_we[cyc];
            if (ev_we[cyc]) mmem[ev_a[cyc]] = ev_d[cyc];
            else cmp_q[cyc+2] = mmem[ev_a[cyc]];
        end
        if (cmp_v[cyc]) begin
            if (cmp_own[cyc]) begin
                e_ack = 1'b1;
                if (cmp_rd[cyc]) m_dbg_q = cmp_q[cyc];
            end else begin
                e_hv = 1'b1;
                if (cmp_rd[cyc]) m_host_q = cmp_q[cyc];
            end
        end
        check("cyc", obs_vec(), {31'b0, e_rd, e_wr, m_reg_a, m_reg_d, e_hv, m_host_q,
                                 e_ack, m_dbg_q, m_ovr});
        if (reg_rd || reg_wr) strobes.push_back(reg_a);

        // debug master: hold request until acknowledged
        if (dbg_req && dbg_ack) begin
            dbg_req = 1'b0;
            dbg_wait = 0;
        end else if (dbg_req) begin
            dbg_wait++;
            if (dbg_wait >= 40) begin
                check("dbg_timeout", 64'(dbg_wait), 64'd39);
                dbg_req = 1'b0;
                dbg_wait = 0;
            end
        end else if (dst) begin
            dbg_req = 1'b1; dbg_we = dwe; dbg_a = da; dbg_d = dd;
        end
        host_req = hreq; host_we = hwe; host_a = ha; host_d = hd;
        host_overrun_clr = clr;
        model_step();
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick(0, 0, 4'd0, 8'd0, 0, 0, 0, 4'd0, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        host_req = 1'b0; host_overrun_clr = 1'b0;
        dbg_req = 1'b0; dbg_wait = 0;
        #1;
        check("rst_zero", obs_vec(), 64'd0);
        model_clear();
        in_rst = 1'b1;
        idle(2);
        reset = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin : main
        logic [3:0] starve_seq [8];
        starve_seq = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd1, 4'd3, 4'd3, 4'd3};
        host_req = 0; host_we = 0; host_a = '0; host_d = '0; host_overrun_clr = 0;
        dbg_req = 0; dbg_we = 0; dbg_a = '0; dbg_d = '0; dbg_wait = 0;
        for (int i = 0; i < 16; i++) mmem[i] = RF_INIT[i];
        model_clear();
        in_rst = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        idle(3);
        reset = 1'b1;
        in_rst = 1'b0;
        idle(2);

        // host write then read back
        tick(1, 1, 4'd2, 8'hA5, 0, 0, 0, 4'd0, 8'd0);
        idle(4);
        tick(1, 0, 4'd2, 8'h00, 0, 0, 0, 4'd0, 8'd0);
        idle(4);
        check("rd_a5", 64'(host_q), 64'h A5);

        // host read a=0, debug read a=1
        tick(1, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, 8'd0);
        idle(4);
        check("rd_42", 64'(host_q), 64'h42);
        tick(0, 0, 4'd0, 8'd0, 0, 1, 0, 4'd1, 8'd0);
        idle(4);
        check("dbg_73", 64'(dbg_q), 64'h73);

        // simultaneous requests: host first, debug next
        strobes.delete();
        tick(1, 0, 4'd0, 8'h00, 0, 1, 0, 4'd1, 8'd0);
        idle(6);
        check("simul_n", 64'(strobes.size()), 64'd2);
        if (strobes.size() == 2) begin
            check("simul_first", 64'(strobes[0]), 64'd0);
            check("simul_second", 64'(strobes[1]), 64'd1);
        end
        check("simul_ovr", 64'(host_overrun), 64'd0);

        // debug starvation limit
        strobes.delete();
        tick(1, 0, 4'd3, 8'h00, 0, 1, 0, 4'd1, 8'd0);
        idle(1);
        repeat (6) begin
            tick(1, 0, 4'd3, 8'h00, 0, 0, 0, 4'd0, 8'd0);
            idle(1);
        end
        idle(6);
        check("starve_n", 64'(strobes.size()), 64'd8);
        for (int i = 0; i < 8 && i < strobes.size(); i++)
            check("starve_seq", 64'(strobes[i]), 64'(starve_seq[i]));
        check("starve_ovr", 64'(host_overrun), 64'd0);

        // three back-to-back host pulses starting while a debug access strobes
        tick(0, 0, 4'd0, 8'd0, 0, 1, 0, 4'd1, 8'd0);
        tick(1, 0, 4'd4, 8'h00, 0, 0, 0, 4'd0, 8'd0);
        tick(1, 0, 4'd5, 8'h00, 0, 0, 0, 4'd0, 8'd0);
        tick(1, 0, 4'd6, 8'h00, 0, 0, 0, 4'd0, 8'd0);
        idle(1);
        check("ovr_set", 64'(host_overrun), 64'd1);
        tick(0, 0, 4'd0, 8'd0, 1, 0, 0, 4'd0, 8'd0);
        idle(1);
        check("ovr_clr", 64'(host_overrun), 64'd0);
        idle(4);

        // reset during a debug strobe, then a normal debug access
        tick(0, 0, 4'd0, 8'd0, 0, 1, 0, 4'd1, 8'd0);
        do_reset();
        idle(4);
        tick(0, 0, 4'd0, 8'd0, 0, 1, 0, 4'd1, 8'd0);
        idle(4);
        check("rst_dbg_73", 64'(dbg_q), 64'h73);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
